dout_writer: RTL and testbench
==============================

Name: dout_writer

Overview:
Transmit-side counterpart of DoutReader. It serialises eight 24-bit channel words onto the 4-lane ADC data-output interface (drdy, dclk, dout0..3). It is used as an ADC emulator for loopback tests of the acquisition chain and for driving a second board's reader over PMOD. One frame is sent per accepted tick_i.

Parameters:
NUM_BITS, 24, bits per channel word
DCLK_DIV, 4, clk_i cycles per dclk half-period; legal range >=1
CH_PER_LANE, 2, channels per lane; fixed, not varied in this revision

Ports:
clk_i  in  1  system clock
reset_i  in  1  asynchronous, active-low reset
tick_i  in  1  frame request; single-cycle strobe
clear_i  in  1  synchronous clear of overrun_o
ch1_i..ch8_i  in  24 each, signed  channel words, sampled only when a frame is accepted
ready_o  out  1  high when idle and able to accept tick_i
drdy_o  out  1  data-ready strobe on the wire
dclk_o  out  1  serial bit clock; idles low
dout0_o..dout3_o  out  1 each  serial data lanes
done_o  out  1  one-cycle pulse when a frame completes
overrun_o  out  1  sticky flag: a tick_i was dropped

Behaviour:
- Reset (reset_i=0, asynchronous):
  - State goes to IDLE.
  - drdy_o=0, dclk_o=0, all dout=0, done_o=0, overrun_o=0, ready_o=1.
  - Effect is immediate, including mid-frame. A partial frame is abandoned and never resumed.
- Lane mapping:
  - lane0 carries ch1 then ch2; lane1 carries ch3 then ch4; lane2 carries ch5 then ch6; lane3 carries ch7 then ch8.
  - Each word is sent MSB first, so each lane carries 48 bits.
- Wire timing: dout changes only while dclk_o is low (at the falling edge or at the drdy fall). The receiver samples on the dclk rising edge.
- States:
  - IDLE:
    - ready_o=1; drdy, dclk, dout are all 0.
    - On tick_i=1: latch ch1_i..ch8_i into two 48-bit shift registers per lane, load the counters, and go to DRDY.
  - DRDY:
    - drdy_o=1 for exactly 2*DCLK_DIV cycles; dclk_o=0; ready_o=0.
    - Then go to SHIFT.
  - SHIFT:
    - drdy_o=0. The first SHIFT cycle drives bit 47 (the MSB of the first word) on each lane.
    - Per bit: dclk_o low for DCLK_DIV cycles, then high for DCLK_DIV cycles. On the high-to-low transition the next bit is driven.
    - The bit counter runs 47 down to 0.
    - After the high phase of bit 0: go to IDLE with dclk_o=0 and dout=0. done_o=1 for that single cycle, and ready_o=1 in the same cycle.
- Latency (tick_i sampled at cycle 0, D=DCLK_DIV):
  - drdy_o rises at cycle 1.
  - SHIFT begins at cycle 2D+1.
  - The first dclk rise is at cycle 3D+1.
  - done_o is asserted at cycle 98D+1 (393 for D=4).
- Back-to-back frames: a tick_i in the done_o cycle is accepted, so drdy_o rises the next cycle.
- tick_i while ready_o=0:
  - The tick is ignored; the frame in flight is unaffected.
  - overrun_o is set to 1 and stays set until clear_i=1.
  - If clear_i and a dropped tick coincide, set wins (overrun_o=1).
- Latched data: channel inputs are not sampled after acceptance. Input changes mid-frame have no effect.
- Counters: the half-period counter is sized clog2(DCLK_DIV)+1 and the bit counter is 6 bits. There is no wrap-around beyond the defined terminal counts.
- Registering: all outputs are registered (no combinational paths from inputs to wire outputs).

Test Plan:
1. Single frame, D=4:
   - Stimulus: ch1=0x800001, ch2=0x7FFFFE, ch3..ch8=0x123456, 0xABCDEF, 0, 0xFFFFFF, 0x555555, 0xAAAAAA; one tick_i.
   - Required: drdy_o high cycles 1–8; exactly 48 dclk rises. Bits sampled on the rising edges reconstruct all 8 words exactly. done_o only at cycle 393.
2. Loopback:
   - Stimulus: connect dout_writer to DoutReader and send 100 frames of random signed words.
   - Required: reader ch1_o..ch8_o equal the sent words; 100 reader ticks; overrun_o=0.
3. Back-to-back and overrun:
   - Stimulus: tick_i in the done_o cycle, then another tick_i at cycle 10 of the new frame.
   - Required: second frame starts with no gap cycle. The third tick is dropped and overrun_o=1. With clear_i=1 for one cycle, overrun_o=0 next cycle.
4. Reset mid-frame:
   - Stimulus: assert reset_i low at bit 20, asynchronously between edges.
   - Required: drdy, dclk, dout all 0 immediately and ready_o=1. After release, a new tick_i produces a clean full frame with correct data.
5. D=1 corner:
   - Stimulus: one frame.
   - Required: drdy_o high 2 cycles; dclk_o alternates each cycle; done_o at cycle 99; data correct.
6. Input stability:
   - Stimulus: change all ch*_i every cycle during a frame.
   - Required: transmitted bits equal the values latched at the accept cycle.

Source files
------------

// File: rtl/dout_writer_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dout_writer_if
// Wire bundle of the 4-lane ADC data-output link (drdy, dclk, dout0..3).
// The writer drives it through the master modport, a reader listens on slave.
// Revision: 1.0
// ----------------------------------------------------------------------------
interface dout_writer_if;
  logic drdy;
  logic dclk;
  logic dout0;
  logic dout1;
  logic dout2;
  logic dout3;

  modport master (output drdy, dclk, dout0, dout1, dout2, dout3);
  modport slave  (input  drdy, dclk, dout0, dout1, dout2, dout3);
endinterface
`default_nettype wire

// File: rtl/dout_writer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dout_writer
// ADC emulator: serialises eight channel words onto four data lanes, two
// words per lane MSB first, framed by a drdy strobe and a divided bit clock.
// Revision: 1.0
// ----------------------------------------------------------------------------
module dout_writer #(
  parameter int NUM_BITS    = 24,
  parameter int DCLK_DIV    = 4,
  parameter int CH_PER_LANE = 2
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       tick_i,
  input  logic                       clear_i,
  input  logic signed [NUM_BITS-1:0] ch1_i,
  input  logic signed [NUM_BITS-1:0] ch2_i,
  input  logic signed [NUM_BITS-1:0] ch3_i,
  input  logic signed [NUM_BITS-1:0] ch4_i,
  input  logic signed [NUM_BITS-1:0] ch5_i,
  input  logic signed [NUM_BITS-1:0] ch6_i,
  input  logic signed [NUM_BITS-1:0] ch7_i,
  input  logic signed [NUM_BITS-1:0] ch8_i,
  output logic                       ready_o,
  output logic                       done_o,
  output logic                       overrun_o,
  dout_writer_if.master              bus
);

  localparam int c_LANE_BITS = NUM_BITS * CH_PER_LANE;
  // Counter covers a full bit period (2*DCLK_DIV cycles) counting down to 0.
  localparam int c_CW = $clog2(DCLK_DIV) + 1;
  localparam logic [c_CW-1:0] c_HALF     = c_CW'(DCLK_DIV);
  localparam logic [c_CW-1:0] c_LOAD     = c_CW'(2 * DCLK_DIV - 1);
  localparam logic [5:0]      c_BIT_LOAD = 6'(c_LANE_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRDY  = 2'd1,
    S_SHIFT = 2'd2
  } state_t;

  state_t                      r_state, w_state;
  logic [c_CW-1:0]             r_cnt, w_cnt;
  logic [5:0]                  r_bit, w_bit;
  logic [3:0][c_LANE_BITS-1:0] r_sh, w_sh;
  logic                        r_drdy, w_drdy;
  logic                        r_dclk, w_dclk;
  logic [3:0]                  r_dout, w_dout;
  logic                        r_done, w_done;
  logic                        r_ready, w_ready;
  logic                        r_ovr, w_ovr;
  logic                        w_step;

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_bit   = r_bit;
    w_sh    = r_sh;
    w_drdy  = 1'b0;
    w_dclk  = 1'b0;
    w_dout  = 4'b0000;
    w_done  = 1'b0;
    w_ready = 1'b0;
    w_step  = 1'b0;

    // A dropped tick sets the flag even if clear arrives in the same cycle.
    if (tick_i && (r_state != S_IDLE)) begin
      w_ovr = 1'b1;
    end else if (clear_i) begin
      w_ovr = 1'b0;
    end else begin
      w_ovr = r_ovr;
    end

    case (r_state)
      S_IDLE: begin
        if (tick_i) begin
          w_state = S_DRDY;
          w_cnt   = c_LOAD;
          w_drdy  = 1'b1;
          w_sh[0] = {ch1_i, ch2_i};
          w_sh[1] = {ch3_i, ch4_i};
          w_sh[2] = {ch5_i, ch6_i};
          w_sh[3] = {ch7_i, ch8_i};
        end else begin
          w_ready = 1'b1;
        end
      end
      S_DRDY: begin
        if (r_cnt == '0) begin
          w_state = S_SHIFT;
          w_cnt   = c_LOAD;
          w_bit   = c_BIT_LOAD;
          w_step  = 1'b1;
        end else begin
          w_cnt  = r_cnt - c_CW'(1);
          w_drdy = 1'b1;
        end
      end
      S_SHIFT: begin
        if (r_cnt != '0) begin
          // Upper half of the count is the low phase, lower half the high phase.
          w_cnt  = r_cnt - c_CW'(1);
          w_dclk = (r_cnt <= c_HALF);
          w_dout = r_dout;
        end else if (r_bit == '0) begin
          w_state = S_IDLE;
          w_done  = 1'b1;
          w_ready = 1'b1;
        end else begin
          w_bit  = r_bit - 6'd1;
          w_cnt  = c_LOAD;
          w_step = 1'b1;
        end
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase

    // Present the next MSB on every lane while dclk is low, then shift it out.
    if (w_step) begin
      for (int l = 0; l < 4; l++) begin
        w_dout[l] = r_sh[l][c_LANE_BITS-1];
        w_sh[l]   = {r_sh[l][c_LANE_BITS-2:0], 1'b0};
      end
    end
  end

  // State, counters, shift registers and registered outputs.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_sh    <= '0;
      r_drdy  <= 1'b0;
      r_dclk  <= 1'b0;
      r_dout  <= 4'b0000;
      r_done  <= 1'b0;
      r_ready <= 1'b1;
      r_ovr   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_bit   <= w_bit;
      r_sh    <= w_sh;
      r_drdy  <= w_drdy;
      r_dclk  <= w_dclk;
      r_dout  <= w_dout;
      r_done  <= w_done;
      r_ready <= w_ready;
      r_ovr   <= w_ovr;
    end
  end

  assign bus.drdy  = r_drdy;
  assign bus.dclk  = r_dclk;
  assign bus.dout0 = r_dout[0];
  assign bus.dout1 = r_dout[1];
  assign bus.dout2 = r_dout[2];
  assign bus.dout3 = r_dout[3];
  assign ready_o   = r_ready;
  assign done_o    = r_done;
  assign overrun_o = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_dout_writer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_dout_writer
// Self-checking bench: a wire-level receiver rebuilds each lane from bits taken
// on dclk rising edges and compares them, plus frame timing, against values
// derived from the channel-to-lane mapping.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_dout_writer;

  typedef logic [7:0][23:0] chans_t;
  typedef logic [3:0][47:0] lanes_t;
  typedef struct {
    chans_t ch;
    lanes_t lane;
  } vec_t;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  logic   tick4 = 1'b0;
  logic   tick1 = 1'b0;
  logic   clear = 1'b0;
  chans_t ch = '0;
  logic   rdy4, done4, ovr4, rdy1, done1, ovr1;

  int checks = 0;
  int errors = 0;

  dout_writer_if if4 ();
  dout_writer_if if1 ();

  dout_writer #(.NUM_BITS(24), .DCLK_DIV(4), .CH_PER_LANE(2)) dut4 (
    .clk_i(clk), .reset_i(rst_n), .tick_i(tick4), .clear_i(clear),
    .ch1_i(ch[0]), .ch2_i(ch[1]), .ch3_i(ch[2]), .ch4_i(ch[3]),
    .ch5_i(ch[4]), .ch6_i(ch[5]), .ch7_i(ch[6]), .ch8_i(ch[7]),
    .ready_o(rdy4), .done_o(done4), .overrun_o(ovr4), .bus(if4.master)
  );

  dout_writer #(.NUM_BITS(24), .DCLK_DIV(1), .CH_PER_LANE(2)) dut1 (
    .clk_i(clk), .reset_i(rst_n), .tick_i(tick1), .clear_i(clear),
    .ch1_i(ch[0]), .ch2_i(ch[1]), .ch3_i(ch[2]), .ch4_i(ch[3]),
    .ch5_i(ch[4]), .ch6_i(ch[5]), .ch7_i(ch[6]), .ch8_i(ch[7]),
    .ready_o(rdy1), .done_o(done1), .overrun_o(ovr1), .bus(if1.master)
  );

  always #5 clk = ~clk;

  // Results of the most recent captured frame.
  lanes_t cap_lanes;
  int cap_drdy_first, cap_drdy_last, cap_drdy_cnt;
  int cap_rises, cap_first_rise, cap_done, cap_viol;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic chans_t pack8(input logic [23:0] c1, c2, c3, c4, c5, c6, c7, c8);
    return {c8, c7, c6, c5, c4, c3, c2, c1};
  endfunction

  // Lane l carries channel 2l+1 then 2l+2, each MSB first.
  function automatic lanes_t model(input chans_t c);
    lanes_t m;
    for (int l = 0; l < 4; l++) m[l] = {c[2*l], c[2*l+1]};
    return m;
  endfunction

  function automatic chans_t rand_chans();
    chans_t c;
    for (int k = 0; k < 8; k++) c[k] = 24'($urandom());
    return c;
  endfunction

  task automatic set_tick(input int sel, input logic v);
    if (sel == 0) tick4 = v; else tick1 = v;
  endtask

  task automatic kick(input int sel, input chans_t w);
    @(negedge clk);
    ch = w;
    set_tick(sel, 1'b1);
  endtask

  // Observe one frame. Cycle 1 is the cycle after the accept edge.
  task automatic capture(input int sel, input int d, input int extra_tick,
                         input bit clr_with_tick, input bit scramble,
                         input int reset_rise, input bit chain, input chans_t next_ch);
    logic       pdclk;
    logic [3:0] pdout;
    logic       s_drdy, s_dclk, s_done, s_ready;
    logic [3:0] s_dout;
    pdclk = 1'b0;
    pdout = 4'b0000;
    cap_lanes = '0;
    cap_drdy_first = -1; cap_drdy_last = -1; cap_drdy_cnt = 0;
    cap_rises = 0; cap_first_rise = -1; cap_done = -1; cap_viol = 0;
    @(posedge clk);
    #1 set_tick(sel, 1'b0);
    for (int n = 1; n <= 120 * d + 20; n++) begin
      @(negedge clk);
      s_drdy  = (sel == 0) ? if4.drdy : if1.drdy;
      s_dclk  = (sel == 0) ? if4.dclk : if1.dclk;
      s_dout  = (sel == 0) ? {if4.dout3, if4.dout2, if4.dout1, if4.dout0}
                           : {if1.dout3, if1.dout2, if1.dout1, if1.dout0};
      s_done  = (sel == 0) ? done4 : done1;
      s_ready = (sel == 0) ? rdy4 : rdy1;
      if (s_drdy) begin
        if (cap_drdy_first < 0) cap_drdy_first = n;
        cap_drdy_last = n;
        cap_drdy_cnt++;
      end
      if ((s_dout != pdout) && s_dclk) cap_viol++;
      if (s_drdy && (s_dout != 4'b0000 || s_dclk)) cap_viol++;
      if (s_ready && !s_done) cap_viol++;
      if (s_dclk && !pdclk) begin
        cap_rises++;
        if (cap_first_rise < 0) cap_first_rise = n;
        for (int l = 0; l < 4; l++) cap_lanes[l] = {cap_lanes[l][46:0], s_dout[l]};
      end
      pdclk = s_dclk;
      pdout = s_dout;
      if (scramble) ch = rand_chans();
      set_tick(sel, n == extra_tick);
      clear = clr_with_tick && (n == extra_tick);
      if (reset_rise > 0 && cap_rises == reset_rise && s_dclk) begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_drdy", {63'd0, if4.drdy}, 64'd0);
        chk("rst_async_dclk", {63'd0, if4.dclk}, 64'd0);
        chk("rst_async_dout", {60'd0, if4.dout3, if4.dout2, if4.dout1, if4.dout0}, 64'd0);
        chk("rst_async_ready", {63'd0, rdy4}, 64'd1);
        cap_done = -2;
        break;
      end
      if (s_done) begin
        cap_done = n;
        if (chain) begin
          ch = next_ch;
          set_tick(sel, 1'b1);
        end
        break;
      end
    end
    clear = 1'b0;
  endtask

  task automatic check_frame(input string nm, input int d, input lanes_t exp);
    chk({nm, "_drdy_first"}, 64'(cap_drdy_first), 64'd1);
    chk({nm, "_drdy_last"}, 64'(cap_drdy_last), 64'(2 * d));
    chk({nm, "_drdy_cnt"}, 64'(cap_drdy_cnt), 64'(2 * d));
    chk({nm, "_rises"}, 64'(cap_rises), 64'd48);
    chk({nm, "_first_rise"}, 64'(cap_first_rise), 64'(3 * d + 1));
    chk({nm, "_done_cycle"}, 64'(cap_done), 64'(98 * d + 1));
    chk({nm, "_wire_rules"}, 64'(cap_viol), 64'd0);
    for (int l = 0; l < 4; l++) chk($sformatf("%s_lane%0d", nm, l), 64'(cap_lanes[l]), 64'(exp[l]));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t   vecs[4];
    chans_t w, wb;
    lanes_t e;

    vecs[0].ch   = pack8(24'h800001, 24'h7FFFFE, 24'h123456, 24'hABCDEF,
                         24'h000000, 24'hFFFFFF, 24'h555555, 24'hAAAAAA);
    vecs[0].lane = {48'h555555AAAAAA, 48'h000000FFFFFF, 48'h123456ABCDEF, 48'h8000017FFFFE};
    vecs[1].ch   = '0;
    vecs[1].lane = '0;
    vecs[2].ch   = pack8(24'd1, 24'd2, 24'd3, 24'd4, 24'd5, 24'd6, 24'd7, 24'd8);
    vecs[2].lane = {48'h000007000008, 48'h000005000006, 48'h000003000004, 48'h000001000002};
    vecs[3].ch   = pack8(24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF,
                         24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF);
    vecs[3].lane = {4{48'hFFFFFFFFFFFF}};

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_ready", {63'd0, rdy4}, 64'd1);
    chk("reset_drdy", {63'd0, if4.drdy}, 64'd0);
    chk("reset_dclk", {63'd0, if4.dclk}, 64'd0);
    chk("reset_done", {63'd0, done4}, 64'd0);
    chk("reset_ovr", {63'd0, ovr4}, 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven frames at DCLK_DIV=4
    for (int i = 0; i < 4; i++) begin
      kick(0, vecs[i].ch);
      capture(0, 4, -1, 1'b0, 1'b0, 0, 1'b0, '0);
      check_frame($sformatf("vec%0d", i), 4, vecs[i].lane);
    end

    // DCLK_DIV=1 corner
    kick(1, vecs[0].ch);
    capture(1, 1, -1, 1'b0, 1'b0, 0, 1'b0, '0);
    check_frame("d1", 1, vecs[0].lane);

    // Random frames against the lane model
    for (int i = 0; i < 50; i++) begin
      w = rand_chans();
      e = model(w);
      kick(0, w);
      capture(0, 4, -1, 1'b0, 1'b0, 0, 1'b0, '0);
      chk($sformatf("rand%0d_done", i), 64'(cap_done), 64'd393);
      for (int l = 0; l < 4; l++) chk($sformatf("rand%0d_lane%0d", i, l), 64'(cap_lanes[l]), 64'(e[l]));
    end
    chk("rand_no_overrun", {63'd0, ovr4}, 64'd0);

    // Back-to-back, then a dropped tick coinciding with clear
    w  = rand_chans();
    wb = rand_chans();
    kick(0, w);
    capture(0, 4, -1, 1'b0, 1'b0, 0, 1'b1, wb);
    check_frame("b2b_a", 4, model(w));
    capture(0, 4, 10, 1'b1, 1'b0, 0, 1'b0, '0);
    check_frame("b2b_b", 4, model(wb));
    chk("overrun_set", {63'd0, ovr4}, 64'd1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("overrun_cleared", {63'd0, ovr4}, 64'd0);

    // Reset at bit 20 of a frame, then a clean frame
    kick(0, rand_chans());
    capture(0, 4, -1, 1'b0, 1'b0, 28, 1'b0, '0);
    chk("rst_reached", 64'(cap_done), 64'hFFFF_FFFF_FFFF_FFFE);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    w = rand_chans();
    kick(0, w);
    capture(0, 4, -1, 1'b0, 1'b0, 0, 1'b0, '0);
    check_frame("post_rst", 4, model(w));

    // Channel inputs churn every cycle after acceptance
    w = rand_chans();
    kick(0, w);
    capture(0, 4, -1, 1'b0, 1'b1, 0, 1'b0, '0);
    check_frame("stable", 4, model(w));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
